ram_reader: RTL and testbench

- Read-side companion to the CPU data RAM port. The CPU only writes RAM (cs, wr, addr, data_in); this block reads RAM back.
- On a start pulse it reads a contiguous block of RAM words and streams them out over a valid/ready handshake.
- Used for post-run memory dump to the display/debug path.
- Sits beside the CPU on the RAM bus. The RAM arbitration mux is outside this block.

---
 rtl/ram_reader_if.sv | 41 ++++
 rtl/ram_reader.sv | 126 ++++++++++++
 tb/tb_ram_reader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_reader_if.sv
// Bus bundle between ram_reader and its surroundings: RAM read port, control and output stream.
// Checksum signals exist only when RAM_READER_CHECKSUM_EN is defined.
interface ram_reader_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) ();
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          cs_ram;
  logic          rd_ram;
  logic [AW-1:0] addr_ram;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;
`ifdef RAM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
  logic          checksum_valid;

  modport slave (
    input  start, base_addr, length, ram_data, dout_ready,
    output cs_ram, rd_ram, addr_ram, dout, dout_valid, busy, done, checksum, checksum_valid
  );
  modport master (
    output start, base_addr, length, ram_data, dout_ready,
    input  cs_ram, rd_ram, addr_ram, dout, dout_valid, busy, done, checksum, checksum_valid
  );
`else
  modport slave (
    input  start, base_addr, length, ram_data, dout_ready,
    output cs_ram, rd_ram, addr_ram, dout, dout_valid, busy, done
  );
  modport master (
    output start, base_addr, length, ram_data, dout_ready,
    input  cs_ram, rd_ram, addr_ram, dout, dout_valid, busy, done
  );
`endif
endinterface

// File: rtl/ram_reader.sv
// Reads a contiguous block of RAM and streams it out through a 2-entry buffer (valid/ready).
// Optional running checksum of accepted words is enabled by defining RAM_READER_CHECKSUM_EN.
module ram_reader #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  ram_reader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW:0]       len_q, len_d;
  logic [AW:0]       issued_q, issued_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DW-1:0]     head_q, head_d;
  logic [DW-1:0]     tail_q, tail_d;
  logic [1:0]        inflight_q, inflight_d;
  logic [2:0]        room;
  logic              issue, push, pop, accept_start;

  always_comb begin
    accept_start = (state_q == StIdle) && bus.start;
    push         = vld_q[RD_LAT-1];
    pop          = (cnt_q != 2'd0) && bus.dout_ready;

    inflight_q = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight_q = inflight_q + {1'b0, vld_q[i]};

    // A word leaving this cycle frees its slot for a new read in the same cycle.
    room  = {1'b0, cnt_q} + {1'b0, inflight_q} - {2'b00, pop};
    issue = (state_q == StRun) && (issued_q < len_q) && (room < 3'd2);

    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < int'(RD_LAT); i++) vld_d[i] = vld_q[i-1];

    inflight_d = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflight_d = inflight_d + {1'b0, vld_d[i]};

    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q + {{AW{1'b0}}, issue};
    if (accept_start) begin
      base_d   = bus.base_addr;
      len_d    = bus.length;
      issued_d = '0;
    end

    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = head_q;
    tail_d = tail_q;
    if (pop && (cnt_q == 2'd2)) begin
      head_d = tail_q;
      if (push) tail_d = bus.ram_data;
    end else if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) head_d = bus.ram_data;
      else                                               tail_d = bus.ram_data;
    end

    state_d = state_q;
    unique case (state_q)
      // length=0 also passes through one empty RUN cycle so busy is visible before done.
      StIdle: if (bus.start) state_d = StRun;
      StRun: begin
        if ((issued_d == len_q) && (inflight_d == 2'd0) && (cnt_d == 2'd0)) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  assign bus.cs_ram     = issue;
  assign bus.rd_ram     = issue;
  assign bus.addr_ram   = base_q + issued_q[AW-1:0];
  assign bus.dout       = head_q;
  assign bus.dout_valid = (cnt_q != 2'd0);
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StFin);

`ifdef RAM_READER_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept_start) sum_d = '0;
    else if (pop)     sum_d = sum_q + head_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign bus.checksum       = sum_q;
  assign bus.checksum_valid = (state_q == StFin);
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Directed self-checking bench for ram_reader with a 1-cycle-latency RAM model.
module tb_ram_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_reader_if #(.AW(8), .DW(8)) bus ();

  ram_reader #(.AW(8), .DW(8), .RD_LAT(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (bus.cs_ram) bus.ram_data <= mem[bus.addr_ram];
  end

  int         n_chk = 0;
  int         n_err = 0;
  int         cs_cnt = 0, acc_cnt = 0, vld_cnt = 0, max_pend = 0;
  int         stall_cnt = 0, stall_err = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = '0;
  logic [7:0] addr_log [$];
  logic [7:0] acc_words [$];

  always @(negedge clk) begin
    if (bus.cs_ram) begin
      cs_cnt <= cs_cnt + 1;
      addr_log.push_back(bus.addr_ram);
    end
    if (bus.dout_valid && bus.dout_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_words.push_back(bus.dout);
    end
    if (bus.dout_valid) vld_cnt <= vld_cnt + 1;
    if (cs_cnt - acc_cnt > max_pend) max_pend <= cs_cnt - acc_cnt;
    if (prev_v && !prev_r) begin
      stall_cnt <= stall_cnt + 1;
      if (!(bus.dout_valid && (bus.dout == prev_d))) stall_err <= stall_err + 1;
    end
    prev_v <= bus.dout_valid;
    prev_r <= bus.dout_ready;
    prev_d <= bus.dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else          step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"},    {31'd0, bus.cs_ram},     32'd0);
    check({tag, "_rd"},    {31'd0, bus.rd_ram},     32'd0);
    check({tag, "_addr"},  {24'd0, bus.addr_ram},   32'd0);
    check({tag, "_dout"},  {24'd0, bus.dout},       32'd0);
    check({tag, "_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy},       32'd0);
    check({tag, "_done"},  {31'd0, bus.done},       32'd0);
  endtask

  task automatic kick(input logic [7:0] base, input logic [8:0] len);
    bus.base_addr = base;
    bus.length    = len;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
  endtask

  initial begin
    int         c0, a0, v0;
    bit         seen;
    bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] wrap_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] wrap_data [4] = '{8'h0E, 8'h0F, 8'h10, 8'h11};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.dout_ready = 1'b1;
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Basic block read, ready held high
    c0 = cs_cnt;
    kick(8'h04, 9'd4);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    check("t1_cs0", {31'd0, bus.cs_ram}, 32'd1);
    check("t1_addr0", {24'd0, bus.addr_ram}, 32'h04);
    check("t1_nvalid0", {31'd0, bus.dout_valid}, 32'd0);
    step();
    check("t1_addr1", {24'd0, bus.addr_ram}, 32'h05);
    check("t1_nvalid1", {31'd0, bus.dout_valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", {31'd0, bus.dout_valid}, 32'd1);
      check("t1_dout", {24'd0, bus.dout}, 32'h14 + i);
      step();
    end
    check("t1_done", {31'd0, bus.done}, 32'd1);
    check("t1_busy_low", {31'd0, bus.busy}, 32'd0);
    check("t1_valid_low", {31'd0, bus.dout_valid}, 32'd0);
    check("t1_hold", {24'd0, bus.dout}, 32'h17);
    step();
    check("t1_done_pulse", {31'd0, bus.done}, 32'd0);
    check("t1_cs_count", cs_cnt - c0, 32'd4);

    // Address wrap
    c0 = addr_log.size();
    a0 = acc_words.size();
    kick(8'hFE, 9'd4);
    wait_done(30, seen);
    check("t2_done_seen", {31'd0, seen}, 32'd1);
    step();
    check("t2_ncs", addr_log.size() - c0, 32'd4);
    check("t2_nwords", acc_words.size() - a0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (addr_log.size() > c0 + i) check("t2_addr", {24'd0, addr_log[c0+i]}, {24'd0, wrap_addr[i]});
      if (acc_words.size() > a0 + i) check("t2_data", {24'd0, acc_words[a0+i]}, {24'd0, wrap_data[i]});
    end

    // Backpressure
    a0 = acc_words.size();
    kick(8'h20, 9'd6);
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      if (bus.done) seen = 1'b1;
      else begin
        bus.dout_ready = pat[k % 6];
        step();
      end
    end
    bus.dout_ready = 1'b1;
    check("t3_done_seen", {31'd0, seen}, 32'd1);
    step();
    check("t3_nwords", acc_words.size() - a0, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (acc_words.size() > a0 + i) check("t3_data", {24'd0, acc_words[a0+i]}, 32'h30 + i);
    end
    check("t3_stalled", {31'd0, stall_cnt > 0}, 32'd1);
    check("t3_stable", stall_err, 32'd0);
    check("t3_max_pending", {31'd0, max_pend <= 2}, 32'd1);

    // Zero length
    c0 = cs_cnt;
    v0 = vld_cnt;
    kick(8'h33, 9'd0);
    check("t4_busy", {31'd0, bus.busy}, 32'd1);
    check("t4_ncs", {31'd0, bus.cs_ram}, 32'd0);
    step();
    check("t4_done", {31'd0, bus.done}, 32'd1);
    check("t4_busy_low", {31'd0, bus.busy}, 32'd0);
    step();
    check("t4_done_pulse", {31'd0, bus.done}, 32'd0);
    check("t4_cs_count", cs_cnt - c0, 32'd0);
    check("t4_valid_count", vld_cnt - v0, 32'd0);

`ifdef RAM_READER_CHECKSUM_EN
    mem[8'h60] = 8'hF0;
    mem[8'h61] = 8'h20;
    mem[8'h62] = 8'h05;
    kick(8'h60, 9'd3);
    wait_done(30, seen);
    check("cs_done_seen", {31'd0, seen}, 32'd1);
    check("cs_valid", {31'd0, bus.checksum_valid}, 32'd1);
    check("cs_value", {24'd0, bus.checksum}, 32'h15);
    step();
    check("cs_valid_pulse", {31'd0, bus.checksum_valid}, 32'd0);
    check("cs_hold", {24'd0, bus.checksum}, 32'h15);
`endif

    // Start while busy is ignored
    c0 = cs_cnt;
    a0 = acc_words.size();
    kick(8'h40, 9'd5);
    step();
    step();
    bus.base_addr = 8'h80;
    bus.length = 9'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(30, seen);
    check("t5_done_seen", {31'd0, seen}, 32'd1);
    repeat (3) step();
    check("t5_idle", {31'd0, bus.busy}, 32'd0);
    check("t5_cs_count", cs_cnt - c0, 32'd5);
    check("t5_nwords", acc_words.size() - a0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (acc_words.size() > a0 + i) check("t5_data", {24'd0, acc_words[a0+i]}, 32'h50 + i);
    end

    // Reset mid-transfer, with start asserted alongside
    kick(8'h10, 9'd8);
    repeat (3) step();
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    check_all_zero("t6_rst");
    rst = 1'b0;
    bus.start = 1'b0;
    c0 = cs_cnt;
    v0 = vld_cnt;
    repeat (10) step();
    check("t6_no_valid", vld_cnt - v0, 32'd0);
    check("t6_no_cs", cs_cnt - c0, 32'd0);
    check("t6_busy", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
